sd_cmd_responder: RTL and testbench



---
 rtl/sd_cmd_responder.sv | 183 ++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands, hands them to card logic
// over REQ/ACK, and returns a 48-bit response after an NCR gap. Optional macro: SD_CMD_RESP_CRC_CHECK_EN.
module sd_cmd_responder #(
    parameter int unsigned NCR = 2
) (
    input  logic        CLK_SD_card,
    input  logic        reset,
    input  logic        cmd_from_host,
    output logic        cmd_to_host,
    output logic        cmd_to_host_oe,
    output logic        REQ_out,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    input  logic        ACK_in,
    input  logic [37:0] resp_index_arg,
    input  logic        resp_none,
    output logic        frame_error,
    output logic        busy
);

    localparam int unsigned FRAME_W = 48;
    localparam int unsigned BODY_W  = 40;
    localparam logic [5:0]  LAST_BIT = 6'(FRAME_W - 1);
    localparam logic [5:0]  GAP_LAST = 6'(NCR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RECEIVE, S_CHECK, S_WAIT_ACK, S_GAP, S_SEND
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [45:0]   r_frame;      // received bits [46:1] during capture, [45:0] once complete
    logic [5:0]    r_bit_cnt;
    logic [5:0]    r_gap_cnt;
    logic          r_frame_ok;
    logic [39:0]   r_tx_sr;
    logic [6:0]    r_tx_crc;
    logic          r_cmd_to_host;
    logic          r_oe;
    logic          r_req;
    logic [5:0]    r_cmd_index;
    logic [31:0]   r_cmd_arg;
    logic          r_frame_error;
    logic          r_busy;
    logic          w_crc_ok;
    logic          w_frame_ok;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    logic [6:0] r_rx_crc;

    // Running CRC over received bits [47:8]; the start bit contributes nothing from a zero seed.
    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            r_rx_crc <= '0;
        end else if (r_state == S_IDLE) begin
            r_rx_crc <= '0;
        end else if (r_state == S_RECEIVE && r_bit_cnt < 6'(BODY_W)) begin
            r_rx_crc <= crc7_step(r_rx_crc, cmd_from_host);
        end
    end

    assign w_crc_ok = (r_rx_crc == r_frame[6:0]);
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Validity is judged as the last bit (end bit) arrives, so frame_error lines up with CHECK.
    always_comb begin
        w_state_next = r_state;
        w_frame_ok   = r_frame[45] & cmd_from_host & w_crc_ok;
        case (r_state)
            S_IDLE:     if (!cmd_from_host) w_state_next = S_RECEIVE;
            S_RECEIVE:  if (r_bit_cnt == LAST_BIT) w_state_next = S_CHECK;
            S_CHECK:    w_state_next = r_frame_ok ? S_WAIT_ACK : S_IDLE;
            S_WAIT_ACK: if (ACK_in) w_state_next = resp_none ? S_IDLE : S_GAP;
            S_GAP:      if (r_gap_cnt == GAP_LAST) w_state_next = S_SEND;
            S_SEND:     if (r_bit_cnt == LAST_BIT) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            r_frame       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_frame_ok    <= 1'b0;
            r_tx_sr       <= '0;
            r_tx_crc      <= '0;
            r_cmd_to_host <= 1'b1;
            r_oe          <= 1'b0;
            r_req         <= 1'b0;
            r_cmd_index   <= '0;
            r_cmd_arg     <= '0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_busy        <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (!cmd_from_host) begin
                        r_frame   <= '0;
                        r_bit_cnt <= 6'd1;
                    end
                end
                S_RECEIVE: begin
                    r_frame   <= {r_frame[44:0], cmd_from_host};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_frame_ok    <= w_frame_ok;
                        r_frame_error <= !w_frame_ok;
                    end
                end
                S_CHECK: begin
                    if (r_frame_ok) begin
                        r_cmd_index <= r_frame[45:40];
                        r_cmd_arg   <= r_frame[39:8];
                        r_req       <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (ACK_in) begin
                        r_req     <= 1'b0;
                        r_tx_sr   <= {2'b00, resp_index_arg};
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_cmd_to_host <= r_tx_sr[39];
                        r_oe          <= 1'b1;
                        r_tx_sr       <= {r_tx_sr[38:0], 1'b0};
                        r_tx_crc      <= crc7_step(7'd0, r_tx_sr[39]);
                        r_bit_cnt     <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 6'd1;
                    end
                end
                S_SEND: begin
                    // r_bit_cnt is the index of the bit now on the line; load the following one.
                    if (r_bit_cnt == LAST_BIT) begin
                        r_oe          <= 1'b0;
                        r_cmd_to_host <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        if (r_bit_cnt < 6'(BODY_W - 1)) begin
                            r_cmd_to_host <= r_tx_sr[39];
                            r_tx_sr       <= {r_tx_sr[38:0], 1'b0};
                            r_tx_crc      <= crc7_step(r_tx_crc, r_tx_sr[39]);
                        end else if (r_bit_cnt < LAST_BIT - 6'd1) begin
                            r_cmd_to_host <= r_tx_crc[6];
                            r_tx_crc      <= {r_tx_crc[5:0], 1'b0};
                        end else begin
                            r_cmd_to_host <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_to_host    = r_cmd_to_host;
    assign cmd_to_host_oe = r_oe;
    assign REQ_out        = r_req;
    assign cmd_index      = r_cmd_index;
    assign cmd_arg        = r_cmd_arg;
    assign frame_error    = r_frame_error;
    assign busy           = r_busy;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: directed test-plan cases plus randomized
// command/response transactions checked against a polynomial-division reference model.
module tb_sd_cmd_responder;

    localparam int unsigned NCR = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_from_host;
    logic        cmd_to_host;
    logic        cmd_to_host_oe;
    logic        REQ_out;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        ACK_in;
    logic [37:0] resp_index_arg;
    logic        resp_none;
    logic        frame_error;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sd_cmd_responder #(.NCR(NCR)) dut (
        .CLK_SD_card    (clk),
        .reset          (rst_n),
        .cmd_from_host  (cmd_from_host),
        .cmd_to_host    (cmd_to_host),
        .cmd_to_host_oe (cmd_to_host_oe),
        .REQ_out        (REQ_out),
        .cmd_index      (cmd_index),
        .cmd_arg        (cmd_arg),
        .ACK_in         (ACK_in),
        .resp_index_arg (resp_index_arg),
        .resp_none      (resp_none),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of body * x^7 divided by x^7+x^3+1 (0x89).
    function automatic logic [6:0] crc7_div(input logic [39:0] body);
        logic [46:0] r;
        r = {body, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic frame_valid(input logic [47:0] f);
        logic ok;
        ok = f[46] & f[0];
`ifdef SD_CMD_RESP_CRC_CHECK_EN
        ok = ok & (crc7_div(f[47:8]) == f[7:1]);
`endif
        return ok;
    endfunction

    function automatic logic [47:0] resp_frame(input logic [37:0] r);
        logic [39:0] body;
        body = {2'b00, r};
        return {body, crc7_div(body), 1'b1};
    endfunction

    task automatic send_bits(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_from_host = f[i];
            @(negedge clk);
        end
        cmd_from_host = 1'b1;
    endtask

    task automatic run_txn(input logic [47:0] f, input bit ack_early, input int ack_delay,
                           input logic [37:0] resp, input bit none);
        logic        exp_ok;
        logic [47:0] rx;
        bit          stable;
        bit          released;
        bit          oe_all;
        int          n;
        exp_ok = frame_valid(f);
        if (ack_early) ACK_in = 1'b1;
        send_bits(f);
        ACK_in = 1'b0;
        check_eq("frame_error_in_check", 64'(frame_error), 64'(!exp_ok));
        check_eq("req_low_in_check", 64'(REQ_out), 64'd0);
        check_eq("busy_in_check", 64'(busy), 64'd1);
        @(negedge clk);
        check_eq("req_after_check", 64'(REQ_out), 64'(exp_ok));
        check_eq("frame_error_one_cycle", 64'(frame_error), 64'd0);
        if (!exp_ok) begin
            check_eq("busy_after_reject", 64'(busy), 64'd0);
            return;
        end
        check_eq("cmd_index", 64'(cmd_index), 64'(f[45:40]));
        check_eq("cmd_arg", 64'(cmd_arg), 64'(f[39:8]));
        stable = 1'b1;
        for (int d = 0; d < ack_delay; d++) begin
            cmd_from_host = 1'($urandom);
            @(negedge clk);
            if (REQ_out !== 1'b1 || cmd_index !== f[45:40] || cmd_arg !== f[39:8] || cmd_to_host_oe !== 1'b0)
                stable = 1'b0;
        end
        cmd_from_host = 1'b1;
        if (ack_delay > 0) check_eq("req_hold_stable", 64'(stable), 64'd1);
        resp_index_arg = resp;
        resp_none      = none;
        ACK_in         = 1'b1;
        @(negedge clk);
        ACK_in         = 1'b0;
        resp_index_arg = {6'($urandom), 32'($urandom)};
        resp_none      = 1'($urandom);
        check_eq("req_drop_after_ack", 64'(REQ_out), 64'd0);
        if (none) begin
            check_eq("busy_after_no_resp", 64'(busy), 64'd0);
            check_eq("oe_no_resp", 64'(cmd_to_host_oe), 64'd0);
            return;
        end
        n = 0;
        released = 1'b1;
        while (!cmd_to_host_oe && n < 100) begin
            if (cmd_to_host !== 1'b1) released = 1'b0;
            cmd_from_host = 1'($urandom);
            @(negedge clk);
            n++;
        end
        cmd_from_host = 1'b1;
        check_eq("ncr_latency", 64'(n), 64'(NCR));
        check_eq("line_high_in_gap", 64'(released), 64'd1);
        oe_all = 1'b1;
        rx = '0;
        for (int i = 0; i < 48; i++) begin
            rx = {rx[46:0], cmd_to_host};
            if (cmd_to_host_oe !== 1'b1) oe_all = 1'b0;
            @(negedge clk);
        end
        check_eq("resp_frame", 64'(rx), 64'(resp_frame(resp)));
        check_eq("oe_held_48", 64'(oe_all), 64'd1);
        check_eq("oe_low_after_end", 64'(cmd_to_host_oe), 64'd0);
        check_eq("line_high_after_end", 64'(cmd_to_host), 64'd1);
        check_eq("busy_after_send", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [47:0] f;
        logic [39:0] body;
        int          n;
        rst_n          = 1'b0;
        cmd_from_host  = 1'b1;
        ACK_in         = 1'b0;
        resp_index_arg = '0;
        resp_none      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_to_host", 64'(cmd_to_host), 64'd1);
        check_eq("rst_oe", 64'(cmd_to_host_oe), 64'd0);
        check_eq("rst_req", 64'(REQ_out), 64'd0);
        check_eq("rst_index", 64'(cmd_index), 64'd0);
        check_eq("rst_arg", 64'(cmd_arg), 64'd0);
        check_eq("rst_frame_error", 64'(frame_error), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference-model sanity against the well-known CRC values.
        f = 48'h400000000095;
        check_eq("model_crc_cmd0", 64'(crc7_div(f[47:8])), 64'h4A);

        // CMD0 with no response; ACK already high while idle and receiving.
        run_txn(48'h400000000095, 1'b1, 0, 38'd0, 1'b1);
        // CMD8, zero response payload: stream must be 0x000000000001.
        run_txn(48'h48000001AA87, 1'b0, 0, 38'd0, 1'b0);
        check_eq("model_cmd8_resp", 64'(resp_frame(38'd0)), 64'h000000000001);
        // Framing errors.
        run_txn(48'h000000000095, 1'b0, 0, 38'd0, 1'b1);
        run_txn(48'h400000000094, 1'b0, 0, 38'd0, 1'b1);
        // CRC-field handling depends on the build option.
        run_txn(48'h510000000055, 1'b0, 1, 38'h11_0000_0900, 1'b0);
        run_txn(48'h510000000057, 1'b0, 1, 38'h11_0000_0900, 1'b0);
        // Slow card logic: REQ held for 10 cycles.
        run_txn(48'h4D12345678FF, 1'b0, 10, 38'h0D_DEAD_BEEF, 1'b0);

        for (int t = 0; t < 40; t++) begin
            body = {2'b01, 6'($urandom), 32'($urandom)};
            f = {body, crc7_div(body), 1'b1};
            case ($urandom_range(0, 9))
                0: f[46] = 1'b0;
                1: f[0]  = 1'b0;
                2: f[7:1] = f[7:1] ^ 7'(1 << $urandom_range(0, 6));
                default: ;
            endcase
            run_txn(f, 1'($urandom), int'($urandom_range(0, 5)),
                    {6'($urandom), 32'($urandom)}, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a response aborts and releases the line at once.
        send_bits(48'h48000001AA87);
        @(negedge clk);
        resp_index_arg = 38'h3F_FFFF_FFFF;
        resp_none      = 1'b0;
        ACK_in         = 1'b1;
        @(negedge clk);
        ACK_in = 1'b0;
        n = 0;
        while (!cmd_to_host_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("oe_before_abort", 64'(cmd_to_host_oe), 64'd1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_oe", 64'(cmd_to_host_oe), 64'd0);
        check_eq("abort_line", 64'(cmd_to_host), 64'd1);
        check_eq("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_abort", 64'(busy), 64'd0);
        run_txn(48'h400000000095, 1'b0, 2, 38'h01_2345_6789, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
